// File: rtl/psum_accumulator_if.sv
// Partial-sum input stream and ofmap output handshake between a PE and its accumulator.
interface psum_accumulator_if #(
    parameter int PSUM_W = 10,
    parameter int OUT_W  = 8
);
    logic [PSUM_W-1:0] psum_i;
    logic              psum_valid_i;
    logic [OUT_W-1:0]  out_data_o;
    logic              out_valid_o;
    logic              out_ready_i;

    // master: the PE/consumer side driving psums and ready
    modport master (
        output psum_i, psum_valid_i, out_ready_i,
        input  out_data_o, out_valid_o
    );

    modport slave (
        input  psum_i, psum_valid_i, out_ready_i,
        output out_data_o, out_valid_o
    );
endinterface

// File: rtl/psum_accumulator.sv
// Accumulates NUM_PASSES psum passes into a ROW_LEN buffer and drains saturated ofmap values.
// Optional: define PSUM_ACC_RELU_EN to clamp negative outputs to zero.
//
// state | meaning
// ACCUM | accepting one psum per cycle into acc[idx], advancing idx/pass
// DRAIN | presenting sat(acc[rd_idx]); psums arriving here are dropped
module psum_accumulator #(
    parameter int PSUM_W     = 10,
    parameter int OUT_W      = 8,
    parameter int ROW_LEN    = 4,
    parameter int NUM_PASSES = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear_i,
    psum_accumulator_if.slave   bus,
    output logic                busy_o,
    output logic                overflow_o
);
    localparam int ACC_W  = PSUM_W + $clog2(NUM_PASSES);
    localparam int IDX_W  = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

    localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(ROW_LEN - 1);
    localparam logic [PASS_W-1:0]        LAST_PASS = PASS_W'(NUM_PASSES - 1);
    localparam logic signed [ACC_W-1:0]  SAT_MAX   = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0]  SAT_MIN   = ~SAT_MAX;

    typedef enum logic {ACCUM, DRAIN} state_e;

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [PASS_W-1:0]         pass_q, pass_d;
    logic [IDX_W-1:0]          rd_idx_q, rd_idx_d;
    logic signed [ACC_W-1:0]   acc_q [ROW_LEN];
    logic signed [ACC_W-1:0]   acc_d [ROW_LEN];
    logic [OUT_W-1:0]          out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;
    logic                      busy_q, busy_d;
    logic                      overflow_q, overflow_d;

    logic signed [ACC_W-1:0]   psum_ext;
    logic [IDX_W-1:0]          rd_next;

    function automatic logic [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] c;
        if (v > SAT_MAX)      c = SAT_MAX;
        else if (v < SAT_MIN) c = SAT_MIN;
        else                  c = v;
`ifdef PSUM_ACC_RELU_EN
        if (c[ACC_W-1]) c = '0;
`endif
        return c[OUT_W-1:0];
    endfunction

    assign psum_ext = ACC_W'($signed(bus.psum_i));
    assign rd_next  = rd_idx_q + IDX_W'(1);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pass_d      = pass_q;
        rd_idx_d    = rd_idx_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        overflow_d  = overflow_q;

        if (clear_i) begin
            state_d     = ACCUM;
            idx_d       = '0;
            pass_d      = '0;
            rd_idx_d    = '0;
            overflow_d  = 1'b0;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (bus.psum_valid_i) begin
                        // pass 0 overwrites, so the buffer never needs an explicit clear
                        if (pass_q == '0) acc_d[idx_q] = psum_ext;
                        else              acc_d[idx_q] = acc_q[idx_q] + psum_ext;

                        if (idx_q == LAST_IDX) begin
                            idx_d = '0;
                            if (pass_q == LAST_PASS) begin
                                pass_d      = '0;
                                rd_idx_d    = '0;
                                state_d     = DRAIN;
                                out_valid_d = 1'b1;
                                busy_d      = 1'b1;
                                out_data_d  = sat(acc_d[0]);
                            end else begin
                                pass_d = pass_q + PASS_W'(1);
                            end
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (bus.psum_valid_i) overflow_d = 1'b1;
                    if (out_valid_q && bus.out_ready_i) begin
                        if (rd_idx_q == LAST_IDX) begin
                            state_d     = ACCUM;
                            rd_idx_d    = '0;
                            idx_d       = '0;
                            pass_d      = '0;
                            out_valid_d = 1'b0;
                            busy_d      = 1'b0;
                        end else begin
                            rd_idx_d   = rd_next;
                            out_data_d = sat(acc_q[rd_next]);
                        end
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            idx_q       <= '0;
            pass_q      <= '0;
            rd_idx_q    <= '0;
            for (int i = 0; i < ROW_LEN; i++) acc_q[i] <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pass_q      <= pass_d;
            rd_idx_q    <= rd_idx_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.out_data_o  = out_data_q;
    assign bus.out_valid_o = out_valid_q;
    assign busy_o          = busy_q;
    assign overflow_o      = overflow_q;
endmodule

// File: tb/tb_psum_accumulator.sv
// Directed-vector bench for psum_accumulator with hand-computed ofmap rows.
module tb_psum_accumulator;
    logic clk;
    logic rst_n;
    logic clear_i;
    logic busy_o;
    logic overflow_o;
    int   n_vec;
    int   n_err;

`ifdef PSUM_ACC_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    psum_accumulator_if #(.PSUM_W(10), .OUT_W(8)) bus ();

    psum_accumulator #(
        .PSUM_W(10), .OUT_W(8), .ROW_LEN(4), .NUM_PASSES(3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (clear_i),
        .bus        (bus.slave),
        .busy_o     (busy_o),
        .overflow_o (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Called at a negedge; drives 12 psums on consecutive cycles, returns at the negedge after the last.
    task automatic feed_row(input int v [12]);
        for (int i = 0; i < 12; i++) begin
            bus.psum_i       = 10'(v[i]);
            bus.psum_valid_i = 1'b1;
            @(negedge clk);
        end
        bus.psum_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear_i = 1'b0;
        bus.psum_i = '0; bus.psum_valid_i = 1'b0; bus.out_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.out_valid_o !== 1'b0 || bus.out_data_o !== 8'd0 || busy_o !== 1'b0 || overflow_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got valid=%0b data=%0d busy=%0b ovf=%0b expected all 0",
                     bus.out_valid_o, bus.out_data_o, busy_o, overflow_o);
        end
    endtask

    task automatic test_basic_row();
        int v [12];
        logic signed [7:0] exp [4];
        v   = '{10, 20, 30, 40, 10, 20, 30, 40, 10, 20, 30, 40};
        exp = '{8'sd30, 8'sd60, 8'sd90, 8'sd120};
        for (int i = 0; i < 12; i++) begin
            if (i == 11) begin
                n_vec++;
                if (bus.out_valid_o !== 1'b0) begin
                    n_err++;
                    $display("FAIL basic_early_valid: got %0b expected 0", bus.out_valid_o);
                end
            end
            bus.psum_i = 10'(v[i]); bus.psum_valid_i = 1'b1;
            @(negedge clk);
        end
        bus.psum_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (bus.out_valid_o !== 1'b1 || busy_o !== 1'b1 || $signed(bus.out_data_o) !== exp[i]) begin
                n_err++;
                $display("FAIL basic_data[%0d]: got valid=%0b busy=%0b data=%0d expected 1 1 %0d",
                         i, bus.out_valid_o, busy_o, $signed(bus.out_data_o), exp[i]);
            end
            @(negedge clk);
        end
        n_vec++;
        if (bus.out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL basic_end: got valid=%0b busy=%0b expected 0 0", bus.out_valid_o, busy_o);
        end
    endtask

    task automatic test_back_to_back();
        int v [12];
        logic signed [7:0] exp [4];
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 12; i++) v[i] = (r == 0) ? (i % 4) + 1 : 8;
            for (int i = 0; i < 4; i++) exp[i] = (r == 0) ? 8'(3 * (i + 1)) : 8'sd24;
            feed_row(v);
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (bus.out_valid_o !== 1'b1 || $signed(bus.out_data_o) !== exp[i]) begin
                    n_err++;
                    $display("FAIL b2b_data[%0d][%0d]: got valid=%0b data=%0d expected 1 %0d",
                             r, i, bus.out_valid_o, $signed(bus.out_data_o), exp[i]);
                end
                @(negedge clk);
            end
        end
        n_vec++;
        if (bus.out_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_end: got valid=%0b expected 0", bus.out_valid_o);
        end
    endtask

    task automatic test_saturation();
        int v [12];
        logic signed [7:0] exp;
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 12; i++)
                v[i] = (s == 0) ? 511 : (s == 1) ? -512 : (i < 4) ? 100 : (i < 8) ? -50 : -60;
            exp = (s == 0) ? 8'sd127 : (s == 1) ? (RELU ? 8'sd0 : -8'sd128) : (RELU ? 8'sd0 : -8'sd10);
            feed_row(v);
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (bus.out_valid_o !== 1'b1 || $signed(bus.out_data_o) !== exp) begin
                    n_err++;
                    $display("FAIL sat_data[%0d][%0d]: got valid=%0b data=%0d expected 1 %0d",
                             s, i, bus.out_valid_o, $signed(bus.out_data_o), exp);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_backpressure();
        int v [12];
        logic signed [7:0] exp [4];
        v   = '{5, 6, 7, 8, 5, 6, 7, 8, 5, 6, 7, 8};
        exp = '{8'sd15, 8'sd18, 8'sd21, 8'sd24};
        bus.out_ready_i = 1'b0;
        feed_row(v);
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (bus.out_valid_o !== 1'b1 || busy_o !== 1'b1 || $signed(bus.out_data_o) !== exp[0]) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got valid=%0b busy=%0b data=%0d expected 1 1 %0d",
                         i, bus.out_valid_o, busy_o, $signed(bus.out_data_o), exp[0]);
            end
            @(negedge clk);
        end
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (bus.out_valid_o !== 1'b1 || $signed(bus.out_data_o) !== exp[i]) begin
                n_err++;
                $display("FAIL bp_data[%0d]: got valid=%0b data=%0d expected 1 %0d",
                         i, bus.out_valid_o, $signed(bus.out_data_o), exp[i]);
            end
            @(negedge clk);
        end
        n_vec++;
        if (bus.out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL bp_end: got valid=%0b busy=%0b expected 0 0", bus.out_valid_o, busy_o);
        end
    endtask

    task automatic test_drop_in_drain();
        int v [12];
        for (int i = 0; i < 12; i++) v[i] = 2;
        bus.out_ready_i = 1'b0;
        feed_row(v);
        bus.psum_i = 10'd99; bus.psum_valid_i = 1'b1;
        @(negedge clk);
        bus.psum_valid_i = 1'b0;
        n_vec++;
        if (overflow_o !== 1'b1 || bus.out_valid_o !== 1'b1 || $signed(bus.out_data_o) !== 8'sd6) begin
            n_err++;
            $display("FAIL drop_flag: got ovf=%0b valid=%0b data=%0d expected 1 1 6",
                     overflow_o, bus.out_valid_o, $signed(bus.out_data_o));
        end
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if ($signed(bus.out_data_o) !== 8'sd6) begin
                n_err++;
                $display("FAIL drop_data[%0d]: got %0d expected 6", i, $signed(bus.out_data_o));
            end
            @(negedge clk);
        end
        n_vec++;
        if (overflow_o !== 1'b1 || busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL drop_sticky: got ovf=%0b busy=%0b expected 1 1", overflow_o, busy_o);
        end
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        n_vec++;
        if (overflow_o !== 1'b0 || busy_o !== 1'b0 || bus.out_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL drop_clear: got ovf=%0b busy=%0b valid=%0b expected 0 0 0",
                     overflow_o, busy_o, bus.out_valid_o);
        end
        for (int i = 0; i < 12; i++) v[i] = 3;
        feed_row(v);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (bus.out_valid_o !== 1'b1 || $signed(bus.out_data_o) !== 8'sd9) begin
                n_err++;
                $display("FAIL drop_after_clear[%0d]: got valid=%0b data=%0d expected 1 9",
                         i, bus.out_valid_o, $signed(bus.out_data_o));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_row();
        int v [12];
        for (int i = 0; i < 6; i++) begin
            bus.psum_i = 10'd50; bus.psum_valid_i = 1'b1;
            @(negedge clk);
        end
        bus.psum_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.out_valid_o !== 1'b0 || bus.out_data_o !== 8'd0 || busy_o !== 1'b0 || overflow_o !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_state: got valid=%0b data=%0d busy=%0b ovf=%0b expected all 0",
                     bus.out_valid_o, bus.out_data_o, busy_o, overflow_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) v[i] = 1;
        feed_row(v);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (bus.out_valid_o !== 1'b1 || $signed(bus.out_data_o) !== 8'sd3) begin
                n_err++;
                $display("FAIL midrst_row[%0d]: got valid=%0b data=%0d expected 1 3",
                         i, bus.out_valid_o, $signed(bus.out_data_o));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_clear_with_psum();
        int v [12];
        for (int i = 0; i < 5; i++) begin
            bus.psum_i = 10'd7; bus.psum_valid_i = 1'b1;
            @(negedge clk);
        end
        clear_i = 1'b1; bus.psum_i = 10'd100; bus.psum_valid_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0; bus.psum_valid_i = 1'b0;
        n_vec++;
        if (overflow_o !== 1'b0 || busy_o !== 1'b0 || bus.out_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL clr_accum: got ovf=%0b busy=%0b valid=%0b expected 0 0 0",
                     overflow_o, busy_o, bus.out_valid_o);
        end
        for (int i = 0; i < 12; i++) v[i] = 1;
        bus.out_ready_i = 1'b0;
        feed_row(v);
        clear_i = 1'b1; bus.psum_i = 10'd5; bus.psum_valid_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0; bus.psum_valid_i = 1'b0; bus.out_ready_i = 1'b1;
        n_vec++;
        if (overflow_o !== 1'b0 || bus.out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL clr_drain: got ovf=%0b valid=%0b busy=%0b expected 0 0 0",
                     overflow_o, bus.out_valid_o, busy_o);
        end
        for (int i = 0; i < 12; i++) v[i] = 4;
        feed_row(v);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (bus.out_valid_o !== 1'b1 || $signed(bus.out_data_o) !== 8'sd12) begin
                n_err++;
                $display("FAIL clr_row[%0d]: got valid=%0b data=%0d expected 1 12",
                         i, bus.out_valid_o, $signed(bus.out_data_o));
            end
            @(negedge clk);
        end
        n_vec++;
        if (bus.out_valid_o !== 1'b0 || overflow_o !== 1'b0) begin
            n_err++;
            $display("FAIL clr_end: got valid=%0b ovf=%0b expected 0 0", bus.out_valid_o, overflow_o);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic_row();
        test_back_to_back();
        test_saturation();
        test_backpressure();
        test_drop_in_drain();
        test_reset_mid_row();
        test_clear_with_psum();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
